// File: rtl/div_share_arbiter.sv
// Round-robin front end that time-shares one pipelined signed divider among NREQ
// requesters, tagging each operation so its result is routed back to its owner.
module div_share_arbiter #(
   parameter int unsigned Z_WIDTH = 16,
   parameter int unsigned D_WIDTH = Z_WIDTH / 2,
   parameter int unsigned PIPE    = D_WIDTH + 3,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*Z_WIDTH-1:0]      req_z,
   input  logic [NREQ*D_WIDTH-1:0]      req_d,
   output logic [NREQ-1:0]              rsp_valid,
   input  logic [NREQ-1:0]              rsp_ready,
   output logic [D_WIDTH:0]             rsp_q,
   output logic [D_WIDTH:0]             rsp_s,
   output logic                         rsp_div0,
   output logic                         rsp_ovf,
   output logic                         div_ena,
   output logic [Z_WIDTH-1:0]           div_z,
   output logic [D_WIDTH-1:0]           div_d,
   input  logic [D_WIDTH:0]             div_q,
   input  logic [D_WIDTH:0]             div_s,
   input  logic                         div_div0,
   input  logic                         div_ovf,
   output logic [$clog2(PIPE+1)-1:0]    inflight
);

   localparam int unsigned CW = $clog2(PIPE + 1);

   logic [PIPE-1:0]           tag_v_q, tag_v_d;
   logic [PIPE-1:0][IDW-1:0]  tag_id_q, tag_id_d;
   logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]             inflight_q, inflight_d;

   logic [IDW-1:0]            grant_id;
   logic [IDW-1:0]            last_id;
   logic                      any_req;
   logic                      stall;
   logic                      issue;
   logic                      retire;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned off);
      return IDW'((32'(base) + off) % NREQ);
   endfunction

   assign last_id = tag_id_q[PIPE-1];
   assign stall   = tag_v_q[PIPE-1] & ~rsp_ready[last_id];
   assign div_ena = ~stall;
   assign retire  = tag_v_q[PIPE-1] & div_ena;

   // Round-robin search from rr_ptr; scanning farthest-first lets the nearest requester win.
   always_comb begin
      grant_id = rr_ptr_q;
      any_req  = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (req_valid[rr_idx(rr_ptr_q, NREQ - 1 - k)]) begin
            grant_id = rr_idx(rr_ptr_q, NREQ - 1 - k);
            any_req  = 1'b1;
         end
      end
   end

   assign issue = any_req & div_ena & rst_n;

   // Divider operands and per-requester accept follow the grant only on an issue cycle.
   always_comb begin
      req_ready = '0;
      div_z     = '0;
      div_d     = '0;
      if (issue) begin
         req_ready[grant_id] = 1'b1;
         div_z = req_z[32'(grant_id) * Z_WIDTH +: Z_WIDTH];
         div_d = req_d[32'(grant_id) * D_WIDTH +: D_WIDTH];
      end
   end

   // Tag pipe, pointer and occupancy all freeze together with the divider.
   always_comb begin
      tag_v_d    = tag_v_q;
      tag_id_d   = tag_id_q;
      rr_ptr_d   = rr_ptr_q;
      inflight_d = inflight_q + CW'(issue) - CW'(retire);
      if (div_ena) begin
         tag_v_d  = {tag_v_q[PIPE-2:0], issue};
         tag_id_d = {tag_id_q[PIPE-2:0], grant_id};
      end
      if (issue) begin
         rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : IDW'(grant_id + IDW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q    <= '0;
         tag_id_q   <= '0;
         rr_ptr_q   <= '0;
         inflight_q <= '0;
      end else begin
         tag_v_q    <= tag_v_d;
         tag_id_q   <= tag_id_d;
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (tag_v_q[PIPE-1]) rsp_valid[last_id] = 1'b1;
   end

   assign rsp_q    = div_q;
   assign rsp_s    = div_s;
   assign rsp_div0 = div_div0;
   assign rsp_ovf  = div_ovf;
   assign inflight = inflight_q;

endmodule
